// File: rtl/regs_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback vs. queued mul/div
// results, with a long-latency scoreboard that raises decode hazard stalls.
//
// Ports:
//   clk, rst                    clock, async active-low reset
//   pipe_we/_reg/_data          pipeline writeback request (no backpressure)
//   md_valid/_ready/_reg/_data  long-latency result push into the FIFO
//   md_issue, md_issue_reg      long-latency op issue (sets busy bit)
//   chk_re_*, chk_addr_*        decode source operands to hazard-check
//   stall                       decode hazard stall (combinational)
//   pipe_hold                   pipeline must not write this cycle
//   err                         sticky: pipe write presented during hold
//   wb_we/_write_reg/_write_data registered register-file write port
module regs_wb_arbiter #(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_reg,
  input  logic [31:0] pipe_data,
  input  logic        md_valid,
  output logic        md_ready,
  input  logic [4:0]  md_reg,
  input  logic [31:0] md_data,
  input  logic        md_issue,
  input  logic [4:0]  md_issue_reg,
  input  logic        chk_re_1,
  input  logic        chk_re_2,
  input  logic [4:0]  chk_addr_1,
  input  logic [4:0]  chk_addr_2,
  output logic        stall,
  output logic        pipe_hold,
  output logic        err,
  output logic        wb_we,
  output logic [4:0]  wb_write_reg,
  output logic [31:0] wb_write_data
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(MAX_WAIT + 1);

  localparam logic [PW-1:0] LAST   = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL   = CW'(DEPTH);
  localparam logic [SW-1:0] STARVE = SW'(MAX_WAIT);

  logic [4:0]    q_reg  [DEPTH];
  logic [31:0]   q_data [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [SW-1:0] starve;
  logic [31:0]   busy;
  logic [31:0]   busy_nx;

  logic          pipe_req;
  logic          q_req;
  logic          gnt_p;
  logic          gnt_q;
  logic          push;
  logic          not_full;
  logic [4:0]    head_reg;
  logic [31:0]   head_data;

  assign head_reg  = q_reg[rd_ptr];
  assign head_data = q_data[rd_ptr];

  assign not_full  = (count < FULL);
  // Held low during reset so every output reads 0.
  assign md_ready  = rst & not_full;
  assign pipe_hold = (starve == STARVE);

  assign pipe_req  = pipe_we && (pipe_reg != 5'd0);
  assign q_req     = (count != '0);
  // r0 results complete the handshake but are never stored.
  assign push      = md_valid && not_full && (md_reg != 5'd0);

  assign stall = (chk_re_1 && busy[chk_addr_1])
              || (chk_re_2 && busy[chk_addr_2])
              || (md_issue && busy[md_issue_reg]);

  always_comb begin
    gnt_p = 1'b0;
    gnt_q = 1'b0;
    priority case (1'b1)
      pipe_hold: gnt_q = q_req;
      pipe_req:  gnt_p = 1'b1;
      q_req:     gnt_q = 1'b1;
      default:   ;
    endcase
  end

  // Issue sets after grant clears, so a same-register
  // set and clear leaves the bit set.
  always_comb begin
    busy_nx = busy;
    if (gnt_q)
      busy_nx[head_reg] = 1'b0;
    if (md_issue)
      busy_nx[md_issue_reg] = 1'b1;
    busy_nx[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_reg[wr_ptr]  <= md_reg;
      q_data[wr_ptr] <= md_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
      if (gnt_q)
        rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
      unique case ({push, gnt_q})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve <= '0;
      busy   <= '0;
      err    <= 1'b0;
    end else begin
      if (gnt_q || !q_req)
        starve <= '0;
      else if (gnt_p)
        starve <= starve + SW'(1);
      busy <= busy_nx;
      if (pipe_hold && pipe_req)
        err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_we         <= 1'b0;
      wb_write_reg  <= '0;
      wb_write_data <= '0;
    end else begin
      wb_we <= gnt_p | gnt_q;
      if (gnt_p) begin
        wb_write_reg  <= pipe_reg;
        wb_write_data <= pipe_data;
      end else if (gnt_q) begin
        wb_write_reg  <= head_reg;
        wb_write_data <= head_data;
      end
    end
  end

endmodule
